lc3_decode_sequencer: RTL and testbench

- Sequences the LC-3 decode stage.
- Buffers fetched instructions in a small FIFO and issues them one at a time on the decode bus (enable_decode, dout, npc_in, psr).
- Inserts issue bubbles for memory-class opcodes, holds after control-flow opcodes until the branch resolves, and flushes wrong-path instructions.
- Sits between the fetch unit and the decode block.

---
 rtl/lc3_decode_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lc3_decode_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_decode_sequencer.sv
// LC-3 decode sequencer: FIFO-buffers fetched instructions and issues one per strobe to decode.
// Latency: push into empty FIFO to strobe is 2 cycles; fetch is stalled via instr_ready when full or flushing.
module lc3_decode_sequencer #(
    parameter int          DEPTH     = 4,
    parameter int          MEM_LAT   = 2,
    parameter logic [15:0] RESET_NPC = 16'h3000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    input  logic [15:0] instr_npc,
    output logic        instr_ready,
    input  logic [3:0]  psr_in,
    input  logic        br_resolve,
    input  logic        br_taken,
    output logic        enable_decode,
    output logic [15:0] dout,
    output logic [15:0] npc_in,
    output logic [3:0]  psr,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(2 * MEM_LAT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAT_MEM  = CW'(MEM_LAT);
    localparam logic [CW-1:0] LAT_IND  = CW'(2 * MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_BR_WAIT
    } state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_nonempty;
    logic [31:0]   w_head;
    logic [3:0]    w_op;

    logic          r_enable_decode;
    logic [15:0]   r_dout;
    logic [15:0]   r_npc_in;
    logic [3:0]    r_psr;

    assign w_nonempty  = (r_count != '0);
    assign instr_ready = (r_count < FULL_CNT) && !(br_resolve && br_taken);
    assign w_push      = instr_valid && instr_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_op        = w_head[31:28];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = w_nonempty;
            end
            S_MEM_WAIT: begin
                // The last wait cycle doubles as an issue slot so the bubble count is exact.
                if (r_cnt == '0) begin
                    w_pop       = w_nonempty;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_BR_WAIT: begin
                if (br_resolve) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = br_taken;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_pop) begin
            case (w_op)
                4'b0010, 4'b0110, 4'b0011, 4'b0111: begin
                    w_state_nxt = S_MEM_WAIT;
                    w_cnt_nxt   = LAT_MEM;
                end
                4'b1010, 4'b1011: begin
                    w_state_nxt = S_MEM_WAIT;
                    w_cnt_nxt   = LAT_IND;
                end
                4'b0000, 4'b1100, 4'b0100, 4'b1111: begin
                    w_state_nxt = S_BR_WAIT;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= {instr_data, instr_npc};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable_decode <= 1'b0;
            r_dout          <= 16'h0000;
            r_npc_in        <= RESET_NPC;
            r_psr           <= 4'h0;
        end else begin
            r_enable_decode <= w_pop;
            if (w_pop) begin
                r_dout   <= w_head[31:16];
                r_npc_in <= w_head[15:0];
                r_psr    <= psr_in;
            end
        end
    end

    assign enable_decode = r_enable_decode;
    assign dout          = r_dout;
    assign npc_in        = r_npc_in;
    assign psr           = r_psr;
    assign busy          = (r_state != S_IDLE) || w_nonempty;

endmodule

// File: tb/tb_lc3_decode_sequencer.sv
// Directed bench for lc3_decode_sequencer: issue timing, memory bubbles, branch hold/flush, backpressure, reset.
module tb_lc3_decode_sequencer;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_npc;
    logic        instr_ready;
    logic [3:0]  psr_in;
    logic        br_resolve;
    logic        br_taken;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [3:0]  psr;
    logic        busy;

    int n_pass;
    int n_total;

    lc3_decode_sequencer #(
        .DEPTH    (4),
        .MEM_LAT  (2),
        .RESET_NPC(16'h3000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_npc    (instr_npc),
        .instr_ready  (instr_ready),
        .psr_in       (psr_in),
        .br_resolve   (br_resolve),
        .br_taken     (br_taken),
        .enable_decode(enable_decode),
        .dout         (dout),
        .npc_in       (npc_in),
        .psr          (psr),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [15:0] d, input logic [15:0] n);
        instr_valid = 1'b1;
        instr_data  = d;
        instr_npc   = n;
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] d, input logic [15:0] n);
        check({tag, ".en"},   {31'd0, enable_decode}, 32'd1);
        check({tag, ".dout"}, {16'd0, dout},          {16'd0, d});
        check({tag, ".npc"},  {16'd0, npc_in},        {16'd0, n});
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, ".en"}, {31'd0, enable_decode}, 32'd0);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 16'h0000;
        instr_npc   = 16'h0000;
        psr_in      = 4'h2;
        br_resolve  = 1'b0;
        br_taken    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst.en",    {31'd0, enable_decode}, 32'd0);
        check("rst.dout",  {16'd0, dout},          32'h0000);
        check("rst.npc",   {16'd0, npc_in},        32'h3000);
        check("rst.psr",   {28'd0, psr},           32'h0);
        check("rst.ready", {31'd0, instr_ready},   32'd1);
        check("rst.busy",  {31'd0, busy},          32'd0);
        reset = 1'b1;
        tick();

        // Back-to-back ALU ops: no bubble
        offer(16'h1261, 16'h3001);
        tick();
        chk_quiet("alu.c1");
        offer(16'h5020, 16'h3002);
        tick();
        chk_issue("alu.add", 16'h1261, 16'h3001);
        check("alu.psr", {28'd0, psr}, 32'h2);
        instr_valid = 1'b0;
        tick();
        chk_issue("alu.and", 16'h5020, 16'h3002);
        tick();
        chk_quiet("alu.after");
        check("alu.hold", {16'd0, dout}, 32'h5020);
        check("alu.busy", {31'd0, busy}, 32'd0);

        // LD: two bubble cycles
        psr_in = 4'h5;
        offer(16'h2205, 16'h3003);
        tick();
        offer(16'h1021, 16'h3004);
        tick();
        chk_issue("ld.ld", 16'h2205, 16'h3003);
        check("ld.psr", {28'd0, psr}, 32'h5);
        instr_valid = 1'b0;
        tick();
        chk_quiet("ld.b1");
        tick();
        chk_quiet("ld.b2");
        tick();
        chk_issue("ld.add", 16'h1021, 16'h3004);
        tick();

        // LDI: four bubble cycles
        offer(16'hA205, 16'h3005);
        tick();
        offer(16'h1021, 16'h3006);
        tick();
        chk_issue("ldi.ldi", 16'hA205, 16'h3005);
        instr_valid = 1'b0;
        tick();
        chk_quiet("ldi.b1");
        tick();
        tick();
        tick();
        chk_quiet("ldi.b4");
        check("ldi.busy", {31'd0, busy}, 32'd1);
        tick();
        chk_issue("ldi.add", 16'h1021, 16'h3006);
        tick();

        // BR not taken: hold until resolve, then issue queued ADDs in order
        offer(16'h0E03, 16'h3010);
        tick();
        offer(16'h1041, 16'h3011);
        tick();
        chk_issue("brn.br", 16'h0E03, 16'h3010);
        offer(16'h1082, 16'h3012);
        tick();
        chk_quiet("brn.w1");
        offer(16'h10C3, 16'h3013);
        tick();
        chk_quiet("brn.w2");
        instr_valid = 1'b0;
        tick();
        chk_quiet("brn.w3");
        br_resolve = 1'b1;
        br_taken   = 1'b0;
        #1;
        check("brn.ready", {31'd0, instr_ready}, 32'd1);
        tick();
        br_resolve = 1'b0;
        chk_quiet("brn.res");
        tick();
        chk_issue("brn.a1", 16'h1041, 16'h3011);
        tick();
        chk_issue("brn.a2", 16'h1082, 16'h3012);
        tick();
        chk_issue("brn.a3", 16'h10C3, 16'h3013);
        tick();
        chk_quiet("brn.end");
        check("brn.busy", {31'd0, busy}, 32'd0);

        // BR taken: queued ADDs flushed
        offer(16'h0E03, 16'h3010);
        tick();
        offer(16'h1041, 16'h3011);
        tick();
        chk_issue("brt.br", 16'h0E03, 16'h3010);
        offer(16'h1082, 16'h3012);
        tick();
        offer(16'h10C3, 16'h3013);
        tick();
        instr_valid = 1'b0;
        tick();
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        #1;
        check("brt.ready", {31'd0, instr_ready}, 32'd0);
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        check("brt.busy", {31'd0, busy}, 32'd0);
        chk_quiet("brt.q0");
        tick();
        chk_quiet("brt.q1");
        tick();
        chk_quiet("brt.q2");

        // Taken resolve outside BR_WAIT does not flush
        offer(16'h1DA5, 16'h3020);
        tick();
        instr_valid = 1'b0;
        br_resolve  = 1'b1;
        br_taken    = 1'b1;
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        chk_issue("ign.add", 16'h1DA5, 16'h3020);
        tick();

        // Backpressure while held in BR_WAIT
        offer(16'h0E03, 16'h3030);
        tick();
        offer(16'h1001, 16'h3031);
        tick();
        chk_issue("bp.br", 16'h0E03, 16'h3030);
        offer(16'h1002, 16'h3032);
        tick();
        offer(16'h1003, 16'h3033);
        tick();
        offer(16'h1004, 16'h3034);
        tick();
        offer(16'h1005, 16'h3035);
        #1;
        check("bp.full", {31'd0, instr_ready}, 32'd0);
        tick();
        check("bp.held", {31'd0, instr_ready}, 32'd0);
        br_resolve = 1'b1;
        br_taken   = 1'b0;
        tick();
        br_resolve = 1'b0;
        chk_quiet("bp.res");
        tick();
        chk_issue("bp.i1", 16'h1001, 16'h3031);
        check("bp.ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        chk_issue("bp.i2", 16'h1002, 16'h3032);
        tick();
        chk_issue("bp.i3", 16'h1003, 16'h3033);
        tick();
        chk_issue("bp.i4", 16'h1004, 16'h3034);
        tick();
        chk_issue("bp.i5", 16'h1005, 16'h3035);
        tick();
        chk_quiet("bp.end");
        check("bp.busy", {31'd0, busy}, 32'd0);

        // Reset in MEM_WAIT with three queued entries
        offer(16'h2205, 16'h3040);
        tick();
        offer(16'h1041, 16'h3041);
        tick();
        chk_issue("mr.ld", 16'h2205, 16'h3040);
        offer(16'h1082, 16'h3042);
        tick();
        offer(16'h10C3, 16'h3043);
        tick();
        instr_valid = 1'b0;
        check("mr.busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mr.en",    {31'd0, enable_decode}, 32'd0);
        check("mr.dout",  {16'd0, dout},          32'h0000);
        check("mr.npc",   {16'd0, npc_in},        32'h3000);
        check("mr.psr",   {28'd0, psr},           32'h0);
        check("mr.busy",  {31'd0, busy},          32'd0);
        check("mr.ready", {31'd0, instr_ready},   32'd1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_quiet("mr.quiet");
            check("mr.qbusy", {31'd0, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
